sga_game_fsm: RTL and testbench

//  Parametrised game-flow control unit for the Snake Game Arcade; successor to the fixed-length control FSM.

---
 rtl/sga_game_fsm_if.sv | 45 ++++
 rtl/sga_game_fsm.sv | 164 ++++++++++++++++
 tb/tb_sga_game_fsm.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sga_game_fsm_if.sv
// Control/status bundle between the Snake Game Arcade flow FSM and its neighbours.
// The master side is the top level and the datapath; the slave side is the FSM.
interface sga_game_fsm_if #(
    parameter int SIZE_W  = 6,
    parameter int LIVES_W = 2
);
    logic               start;
    logic               pause;
    logic               is_at_apple;
    logic               is_at_border;
    logic               is_at_body;
    logic               end_play_time;
    logic               render_finish;

    logic [SIZE_W-1:0]  size;
    logic [LIVES_W-1:0] lives_left;
    logic               clear_pos;
    logic               render_clr;
    logic               render_count;
    logic               register_apple;
    logic               reset_apple;
    logic               register_dir;
    logic               move;
    logic               paused;
    logic               finished;
    logic               won;
    logic               lost;
    logic [4:0]         db_state;

    modport master (
        output start, pause, is_at_apple, is_at_border, is_at_body,
               end_play_time, render_finish,
        input  size, lives_left, clear_pos, render_clr, render_count,
               register_apple, reset_apple, register_dir, move,
               paused, finished, won, lost, db_state
    );

    modport slave (
        input  start, pause, is_at_apple, is_at_border, is_at_body,
               end_play_time, render_finish,
        output size, lives_left, clear_pos, render_clr, render_count,
               register_apple, reset_apple, register_dir, move,
               paused, finished, won, lost, db_state
    );
endinterface

// File: rtl/sga_game_fsm.sv
// Game-flow Moore FSM for the Snake Game Arcade: owns size/lives counters,
// sequences apple/render/wait/move/compare steps and defers pauses to frame boundaries.
module sga_game_fsm #(
    parameter int SIZE_W    = 6,
    parameter int INIT_SIZE = 2,
    parameter int WIN_SIZE  = 16,
    parameter int LIVES     = 3,
    parameter int LIVES_W   = 2
) (
    input  logic           clock,
    input  logic           restart,
    sga_game_fsm_if.slave  bus
);

    typedef enum logic [4:0] {
        IDLE              = 5'd0,
        PREPARA           = 5'd1,
        GERA_MACA_INICIAL = 5'd2,
        RENDERIZA         = 5'd3,
        PROXIMO_RENDER    = 5'd4,
        ESPERA            = 5'd5,
        REGISTRA          = 5'd6,
        MOVE              = 5'd7,
        COMPARA           = 5'd8,
        COMEU_MACA        = 5'd9,
        CRESCE            = 5'd10,
        GERA_MACA         = 5'd11,
        FEZ_NADA          = 5'd12,
        COLIDIU           = 5'd13,
        REINICIA          = 5'd14,
        PAUSOU            = 5'd15,
        PERDEU            = 5'd16,
        GANHOU            = 5'd17
    } state_t;

    localparam logic [SIZE_W-1:0]  INIT_SZ  = SIZE_W'(INIT_SIZE);
    localparam logic [SIZE_W-1:0]  WIN_SZ   = SIZE_W'(WIN_SIZE);
    localparam logic [SIZE_W:0]    WIN_EXT  = (SIZE_W+1)'(WIN_SIZE);
    localparam logic [LIVES_W-1:0] LIVES_LD = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] ONE_LIFE = LIVES_W'(1);

    state_t             state, next_state;
    logic [SIZE_W-1:0]  size_q;
    logic [LIVES_W-1:0] lives_q;
    logic               pause_pend;
    logic               will_win;
    logic               collided;
    logic               pend_window;

    // Extended add so WIN_SIZE = 2**SIZE_W-1 cannot wrap the comparison
    assign will_win    = ({1'b0, size_q} + 1'b1) == WIN_EXT;
    assign collided    = bus.is_at_border | bus.is_at_body;
    assign pend_window = (state >= RENDERIZA) && (state <= REINICIA) && (state != ESPERA);

    // State register
    always_ff @(posedge clock or posedge restart) begin
        if (restart) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:              next_state = bus.start ? PREPARA : IDLE;
            PREPARA:           next_state = GERA_MACA_INICIAL;
            GERA_MACA_INICIAL: next_state = RENDERIZA;
            RENDERIZA:         next_state = bus.render_finish ? ESPERA : PROXIMO_RENDER;
            PROXIMO_RENDER:    next_state = RENDERIZA;
            ESPERA: begin
                if (bus.pause || pause_pend) next_state = PAUSOU;
                else if (bus.end_play_time)  next_state = REGISTRA;
                else                         next_state = ESPERA;
            end
            REGISTRA:          next_state = MOVE;
            MOVE:              next_state = COMPARA;
            COMPARA: begin
                if (collided)             next_state = COLIDIU;
                else if (bus.is_at_apple) next_state = COMEU_MACA;
                else                      next_state = FEZ_NADA;
            end
            COMEU_MACA:        next_state = CRESCE;
            CRESCE:            next_state = will_win ? GANHOU : GERA_MACA;
            GERA_MACA:         next_state = RENDERIZA;
            FEZ_NADA:          next_state = RENDERIZA;
            COLIDIU:           next_state = (lives_q == ONE_LIFE) ? PERDEU : REINICIA;
            REINICIA:          next_state = GERA_MACA_INICIAL;
            PAUSOU:            next_state = bus.start ? ESPERA : PAUSOU;
            PERDEU:            next_state = bus.start ? PREPARA : PERDEU;
            GANHOU:            next_state = bus.start ? PREPARA : GANHOU;
            default:           next_state = IDLE;
        endcase
    end

    // Counters change on the edge that leaves their owning state
    always_ff @(posedge clock or posedge restart) begin
        if (restart) begin
            size_q  <= '0;
            lives_q <= '0;
        end else begin
            case (state)
                PREPARA: begin
                    size_q  <= INIT_SZ;
                    lives_q <= LIVES_LD;
                end
                REINICIA: size_q <= INIT_SZ;
                CRESCE:   if (size_q != WIN_SZ) size_q <= size_q + 1'b1;
                COLIDIU:  if (lives_q != '0) lives_q <= lives_q - 1'b1;
                default: ;
            endcase
        end
    end

    // A pause seen mid-frame is remembered and honoured at the next ESPERA
    always_ff @(posedge clock or posedge restart) begin
        if (restart)                                        pause_pend <= 1'b0;
        else if (state == PREPARA)                          pause_pend <= 1'b0;
        else if (next_state == PAUSOU && state != PAUSOU)   pause_pend <= 1'b0;
        else if (pend_window && bus.pause)                  pause_pend <= 1'b1;
    end

    // Output decode (state only)
    always_comb begin
        bus.clear_pos      = 1'b0;
        bus.render_clr     = 1'b0;
        bus.render_count   = 1'b0;
        bus.register_apple = 1'b0;
        bus.reset_apple    = 1'b0;
        bus.register_dir   = 1'b0;
        bus.move           = 1'b0;
        bus.paused         = 1'b0;
        bus.finished       = 1'b0;
        bus.won            = 1'b0;
        bus.lost           = 1'b0;
        case (state)
            IDLE:              bus.render_clr = 1'b1;
            PREPARA, REINICIA: begin
                bus.clear_pos  = 1'b1;
                bus.render_clr = 1'b1;
            end
            PROXIMO_RENDER:    bus.render_count   = 1'b1;
            GERA_MACA_INICIAL,
            GERA_MACA:         bus.register_apple = 1'b1;
            COMEU_MACA:        bus.reset_apple    = 1'b1;
            REGISTRA:          bus.register_dir   = 1'b1;
            MOVE:              bus.move           = 1'b1;
            PAUSOU:            bus.paused         = 1'b1;
            GANHOU: begin
                bus.won      = 1'b1;
                bus.finished = 1'b1;
            end
            PERDEU: begin
                bus.lost     = 1'b1;
                bus.finished = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.size       = size_q;
    assign bus.lives_left = lives_q;
    assign bus.db_state   = state;

endmodule

// File: tb/tb_sga_game_fsm.sv
// Directed-vector bench for sga_game_fsm with WIN_SIZE=4 so a win is reachable in two apples.
module tb_sga_game_fsm;

    localparam int SIZE_W  = 6;
    localparam int LIVES_W = 2;

    logic clock;
    logic restart;
    int   n_vec;
    int   n_err;
    int   rc_cnt;

    sga_game_fsm_if #(.SIZE_W(SIZE_W), .LIVES_W(LIVES_W)) bus ();

    sga_game_fsm #(
        .SIZE_W(SIZE_W), .INIT_SIZE(2), .WIN_SIZE(4), .LIVES(3), .LIVES_W(LIVES_W)
    ) dut (
        .clock   (clock),
        .restart (restart),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic step_st(input string tag, input int exp_st);
        step();
        chk(tag, int'(bus.db_state), exp_st);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rc_cnt = 0;
        restart = 1'b1;
        bus.start = 0; bus.pause = 0; bus.is_at_apple = 0; bus.is_at_border = 0;
        bus.is_at_body = 0; bus.end_play_time = 0; bus.render_finish = 0;
        #12;
        // reset state
        chk("rst_state", int'(bus.db_state), 0);
        chk("rst_size", int'(bus.size), 0);
        chk("rst_lives", int'(bus.lives_left), 0);
        chk("rst_render_clr", int'(bus.render_clr), 1);
        chk("rst_others", int'({bus.clear_pos, bus.render_count, bus.register_apple,
            bus.reset_apple, bus.register_dir, bus.move, bus.paused, bus.finished,
            bus.won, bus.lost}), 0);
        @(negedge clock);
        restart = 1'b0;
        step_st("idle_hold", 0);

        // 1: start -> PREPARA -> GERA_MACA_INICIAL -> RENDERIZA
        bus.start = 1;
        step_st("t1_prepara", 1);
        chk("t1_clear_pos", int'(bus.clear_pos), 1);
        bus.start = 0;
        step_st("t1_gera_ini", 2);
        chk("t1_size", int'(bus.size), 2);
        chk("t1_lives", int'(bus.lives_left), 3);
        chk("t1_reg_apple", int'(bus.register_apple), 1);
        step_st("t1_render", 3);

        // 2: three render iterations then finish
        for (int i = 0; i < 6; i++) begin
            step_st("t2_loop", (i % 2 == 0) ? 4 : 3);
            if (bus.render_count) rc_cnt++;
        end
        bus.render_finish = 1;
        step_st("t2_espera", 5);
        chk("t2_rc_cycles", rc_cnt, 3);

        // 3: eat an apple, size 2 -> 3
        bus.is_at_apple = 1;
        bus.end_play_time = 1;
        step_st("t3_registra", 6);
        chk("t3_reg_dir", int'(bus.register_dir), 1);
        bus.end_play_time = 0;
        step_st("t3_move", 7);
        chk("t3_move_o", int'(bus.move), 1);
        step_st("t3_compara", 8);
        step_st("t3_comeu", 9);
        chk("t3_reset_apple", int'(bus.reset_apple), 1);
        step_st("t3_cresce", 10);
        chk("t3_reset_apple_off", int'(bus.reset_apple), 0);
        step_st("t3_gera", 11);
        chk("t3_size", int'(bus.size), 3);
        step_st("t3_render", 3);
        step_st("t3_espera", 5);

        // 4: second apple reaches WIN_SIZE=4
        bus.end_play_time = 1;
        step_st("t4_registra", 6);
        bus.end_play_time = 0;
        step_st("t4_move", 7);
        step_st("t4_compara", 8);
        step_st("t4_comeu", 9);
        step_st("t4_cresce", 10);
        step_st("t4_ganhou", 17);
        chk("t4_won", int'(bus.won), 1);
        chk("t4_finished", int'(bus.finished), 1);
        chk("t4_size", int'(bus.size), 4);
        step_st("t4_ganhou_hold", 17);
        bus.start = 1;
        step_st("t4_prepara", 1);
        bus.start = 0;
        step_st("t4_gera_ini", 2);
        chk("t4_size_reload", int'(bus.size), 2);
        chk("t4_lives_reload", int'(bus.lives_left), 3);
        step_st("t4_render", 3);
        step_st("t4_espera", 5);

        // 5: collisions beat apples; lives 3 -> 2 -> 1 -> lost
        bus.is_at_border = 1;
        bus.is_at_apple  = 1;
        for (int k = 0; k < 2; k++) begin
            bus.end_play_time = 1;
            step_st("t5_registra", 6);
            bus.end_play_time = 0;
            step_st("t5_move", 7);
            step_st("t5_compara", 8);
            step_st("t5_colidiu", 13);
            step_st("t5_reinicia", 14);
            chk("t5_lives", int'(bus.lives_left), 2 - k);
            chk("t5_clear_pos", int'(bus.clear_pos), 1);
            step_st("t5_gera_ini", 2);
            chk("t5_size", int'(bus.size), 2);
            step_st("t5_render", 3);
            step_st("t5_espera", 5);
        end
        bus.end_play_time = 1;
        step_st("t5_registra3", 6);
        bus.end_play_time = 0;
        step_st("t5_move3", 7);
        step_st("t5_compara3", 8);
        step_st("t5_colidiu3", 13);
        step_st("t5_perdeu", 16);
        chk("t5_lost", int'(bus.lost), 1);
        chk("t5_finished", int'(bus.finished), 1);
        chk("t5_lives0", int'(bus.lives_left), 0);
        chk("t5_size_kept", int'(bus.size), 2);
        bus.is_at_border = 0;
        bus.is_at_apple  = 0;

        // 6: deferred pause, pause-beats-timer, resume, async restart
        bus.start = 1;
        step_st("t6_prepara", 1);
        bus.start = 0;
        step_st("t6_gera_ini", 2);
        step_st("t6_render", 3);
        bus.pause = 1;
        step_st("t6_espera", 5);
        bus.pause = 0;
        step_st("t6_pausou", 15);
        chk("t6_paused", int'(bus.paused), 1);
        step_st("t6_pausou_hold", 15);
        bus.start = 1;
        step_st("t6_resume", 5);
        bus.start = 0;
        step_st("t6_pend_cleared", 5);
        bus.pause = 1;
        bus.end_play_time = 1;
        step_st("t6_pause_wins", 15);
        bus.pause = 0;
        bus.end_play_time = 0;
        bus.start = 1;
        step_st("t6_resume2", 5);
        bus.start = 0;
        bus.end_play_time = 1;
        step_st("t6_registra", 6);
        bus.end_play_time = 0;
        step_st("t6_move", 7);
        #2;
        restart = 1'b1;
        #1;
        chk("t6_rst_state", int'(bus.db_state), 0);
        chk("t6_rst_size", int'(bus.size), 0);
        chk("t6_rst_lives", int'(bus.lives_left), 0);
        chk("t6_rst_move", int'(bus.move), 0);
        chk("t6_rst_render_clr", int'(bus.render_clr), 1);
        @(negedge clock);
        restart = 1'b0;
        step_st("t6_idle_after", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
